// File: rtl/keypad_bcd_scanner_pkg.sv
// Purpose: FSM state type, elevator key codes and keypad key-map helpers.
// Latency: pure combinational helpers, no state.
// Backpressure: none; the codes are consumed by the scanner and the elevator.
package keypad_bcd_scanner_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    EMIT     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [3:0] KEY_LOGIN   = 4'b1011;
  localparam logic [3:0] KEY_ADDUSER = 4'b1100;
  localparam logic [3:0] KEY_ENTER   = 4'b1101;
  localparam logic [3:0] KEY_REMOVE  = 4'b1110;
  localparam logic [3:0] KEY_CLEAR   = 4'b1010;

  // Returns {mapped, code}; r3c3 has no key behind it.
  function automatic logic [4:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    logic [4:0] res;
    case ({row, col})
      4'h0:    res = {1'b1, 4'b0001};
      4'h1:    res = {1'b1, 4'b0010};
      4'h2:    res = {1'b1, 4'b0011};
      4'h3:    res = {1'b1, KEY_LOGIN};
      4'h4:    res = {1'b1, 4'b0100};
      4'h5:    res = {1'b1, 4'b0101};
      4'h6:    res = {1'b1, 4'b0110};
      4'h7:    res = {1'b1, KEY_ADDUSER};
      4'h8:    res = {1'b1, 4'b0111};
      4'h9:    res = {1'b1, 4'b1000};
      4'hA:    res = {1'b1, 4'b1001};
      4'hB:    res = {1'b1, KEY_ENTER};
      4'hC:    res = {1'b1, KEY_CLEAR};
      4'hD:    res = {1'b1, 4'b0000};
      4'hE:    res = {1'b1, KEY_REMOVE};
      default: res = 5'b0_0000;
    endcase
    return res;
  endfunction

  // Index of the lowest low bit of an active-low column pattern.
  function automatic logic [1:0] col_index(input logic [3:0] cols_n);
    logic [1:0] idx;
    if (!cols_n[0])      idx = 2'd0;
    else if (!cols_n[1]) idx = 2'd1;
    else if (!cols_n[2]) idx = 2'd2;
    else                 idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_bcd_scanner_if.sv
// Purpose: keypad pins plus the BCD_management bus toward the elevator.
// Latency: wires only.
// Backpressure: none; key_valid is a fire-and-forget strobe.
interface keypad_bcd_scanner_if;
  logic [3:0] cols;
  logic [3:0] rows;
  logic [3:0] BCD_management;
  logic       key_valid;

  modport master (input cols, output rows, output BCD_management, output key_valid);
  modport slave  (output cols, input rows, input BCD_management, input key_valid);
endinterface

// File: rtl/keypad_bcd_scanner_sync2.sv
// Purpose: 2-FF synchronizer for the asynchronous column sense lines.
// Latency: 2 clocks.
// Backpressure: none; resets to the idle (all released) pattern.
module sync2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d,
  output logic [3:0] q
);
  logic [3:0] meta;

  // Two back-to-back flops; reset value means "no key down".
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= 4'b1111;
      q    <= 4'b1111;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/keypad_bcd_scanner.sv
// Purpose: scans the 4x4 keypad and emits one debounced code per key press.
// Latency: 2 sync clocks + row dwell + DEBOUNCE_CYCLES+1 clocks to key_valid.
// Backpressure: none; key_valid pulses HOLD_CYCLES clocks, code held afterwards.
module keypad_bcd_scanner
  import keypad_bcd_scanner_pkg::*;
#(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int HOLD_CYCLES     = 2
) (
  input logic                    CLK,
  input logic                    RST,
  keypad_bcd_scanner_if.master   kp
);
  localparam int DW = $clog2(SCAN_DIV + 1);
  localparam int BW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_MAX  = BW'(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

  state_t        state, state_nxt;
  logic [1:0]    row_idx, row_idx_nxt;
  logic [DW-1:0] div_cnt, div_cnt_nxt;
  logic [BW-1:0] deb_cnt, deb_cnt_nxt, deb_inc;
  logic [HW-1:0] hold_cnt, hold_cnt_nxt;
  logic [3:0]    lat_cs, lat_cs_nxt;
  logic [3:0]    bcd, bcd_nxt;
  logic          kv, kv_nxt;
  logic [3:0]    cs;
  logic          single_low;
  logic [4:0]    scan_key, lat_key;

  sync2 u_sync (.clk(CLK), .rst(RST), .d(kp.cols), .q(cs));

  assign single_low = ($countones(~cs) == 1);
  assign scan_key   = key_lookup(row_idx, col_index(cs));
  assign lat_key    = key_lookup(row_idx, col_index(lat_cs));
  assign deb_inc    = deb_cnt + BW'(1);

  // Next-state, counters and output registers' next values.
  always_comb begin
    state_nxt    = state;
    row_idx_nxt  = row_idx;
    div_cnt_nxt  = div_cnt;
    deb_cnt_nxt  = deb_cnt;
    hold_cnt_nxt = hold_cnt;
    lat_cs_nxt   = lat_cs;
    bcd_nxt      = bcd;
    kv_nxt       = 1'b0;
    case (state)
      SCAN: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_nxt = '0;
          // Only a single, mapped key freezes the row; ghosts keep scanning.
          if (single_low && scan_key[4]) begin
            lat_cs_nxt  = cs;
            deb_cnt_nxt = '0;
            state_nxt   = DEBOUNCE;
          end else begin
            row_idx_nxt = row_idx + 2'd1;
          end
        end else begin
          div_cnt_nxt = div_cnt + DW'(1);
        end
      end
      DEBOUNCE: begin
        if (cs != lat_cs) begin
          deb_cnt_nxt = '0;
          div_cnt_nxt = '0;
          row_idx_nxt = row_idx + 2'd1;
          state_nxt   = SCAN;
        end else if (deb_inc == DEB_MAX) begin
          deb_cnt_nxt  = '0;
          hold_cnt_nxt = '0;
          bcd_nxt      = lat_key[3:0];
          state_nxt    = EMIT;
        end else begin
          deb_cnt_nxt = deb_inc;
        end
      end
      EMIT: begin
        if (hold_cnt == HOLD_MAX) begin
          state_nxt = RELEASE;
        end else begin
          kv_nxt       = 1'b1;
          hold_cnt_nxt = hold_cnt + HW'(1);
        end
      end
      RELEASE: begin
        if (cs != 4'b1111) begin
          deb_cnt_nxt = '0;
        end else if (deb_inc == DEB_MAX) begin
          deb_cnt_nxt = '0;
          div_cnt_nxt = '0;
          row_idx_nxt = 2'd0;
          state_nxt   = SCAN;
        end else begin
          deb_cnt_nxt = deb_inc;
        end
      end
      default: state_nxt = SCAN;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= SCAN;
      row_idx  <= 2'd0;
      div_cnt  <= '0;
      deb_cnt  <= '0;
      hold_cnt <= '0;
      lat_cs   <= 4'b1111;
      bcd      <= 4'b0000;
      kv       <= 1'b0;
    end else begin
      state    <= state_nxt;
      row_idx  <= row_idx_nxt;
      div_cnt  <= div_cnt_nxt;
      deb_cnt  <= deb_cnt_nxt;
      hold_cnt <= hold_cnt_nxt;
      lat_cs   <= lat_cs_nxt;
      bcd      <= bcd_nxt;
      kv       <= kv_nxt;
    end
  end

  assign kp.rows           = ~(4'b0001 << row_idx);
  assign kp.BCD_management = bcd;
  assign kp.key_valid      = kv;
endmodule
